alu_seq: RTL and testbench

//  Parametrised, registered successor of the 16-bit 74181-style datapath ALU.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_shifter.sv | 59 +++++
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and shifter modes.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_PASS_A = 4'd0,
    OP_PASS_B = 4'd1,
    OP_ADD    = 4'd2,
    OP_SUB    = 4'd3,
    OP_AND    = 4'd4,
    OP_OR     = 4'd5,
    OP_XOR    = 4'd6,
    OP_NOT    = 4'd7,
    OP_DEC    = 4'd8,
    OP_SEXT   = 4'd9,
    OP_SHL    = 4'd10,
    OP_SHR    = 4'd11,
    OP_ASR    = 4'd12,
    OP_MUL    = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_FIN   = 2'd3
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_L = 2'd0,
    SH_R = 2'd1,
    SH_A = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Loadable one-bit-per-cycle shift register with down-counter; exposes the next value
// and the bit leaving this cycle so the owner can register the final result directly.
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             load,
  input  logic             en,
  input  shift_mode_e      mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CW-1:0]    load_cnt,
  output logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q_next_c,
  output logic             out_bit_c
);

  logic [WIDTH-1:0] q;
  shift_mode_e      mode_q;

  always_comb begin
    q_next_c  = q;
    out_bit_c = 1'b0;
    case (mode_q)
      SH_L: begin
        q_next_c  = {q[WIDTH-2:0], 1'b0};
        out_bit_c = q[WIDTH-1];
      end
      SH_R: begin
        q_next_c  = {1'b0, q[WIDTH-1:1]};
        out_bit_c = q[0];
      end
      SH_A: begin
        q_next_c  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit_c = q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!notReset) begin
      q      <= '0;
      cnt    <= '0;
      mode_q <= SH_L;
    end else if (load) begin
      q      <= load_val;
      cnt    <= load_cnt;
      mode_q <= mode;
    end else if (en && cnt != '0) begin
      q   <= q_next_c;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered sequential ALU: single-cycle logic/arith, multi-cycle shifts by N and,
// when ALU_SEQ_MUL_EN is defined, an unsigned shift-add multiply on op 13.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             signed_cmp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zout
);

  localparam int unsigned CW = CNTW + 1;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned HW = WIDTH / 2;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_d;
  logic             cout_d, zout_d, busy_d, done_d;

  alu_op_e          op_c;
  logic [CNTW-1:0]  n_c;
  logic [WIDTH-1:0] b_eff_c, y_c;
  logic [SW-1:0]    sum_c;
  logic             cout_c;

  logic             sh_load, sh_en, sh_out_c;
  shift_mode_e      sh_mode;
  logic [WIDTH-1:0] sh_val, sh_next_c;
  logic [CW-1:0]    sh_cnt_ld, sh_cnt;

  assign op_c    = alu_op_e'(op);
  assign n_c     = b[CNTW-1:0];
  assign b_eff_c = (op_c == OP_SUB) ? ~b : b;
  assign sum_c   = {1'b0, a} + {1'b0, b_eff_c} + SW'(cin);

  // Single-cycle unit; the signed fix flips carry when operand signs differ.
  always_comb begin
    y_c    = '0;
    cout_c = 1'b0;
    case (op_c)
      OP_PASS_A: y_c = a;
      OP_PASS_B: y_c = b;
      OP_ADD, OP_SUB: begin
        y_c    = sum_c[WIDTH-1:0];
        cout_c = sum_c[WIDTH] ^ (signed_cmp & a[WIDTH-1]) ^ (signed_cmp & b[WIDTH-1]);
      end
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_NOT:  y_c = ~a;
      OP_DEC: begin
        y_c    = a - WIDTH'(1);
        cout_c = |a;
      end
      OP_SEXT: begin
        y_c    = {{HW{a[HW-1]}}, a[HW-1:0]};
        cout_c = a[HW-1];
      end
      default: ;
    endcase
  end

  alu_seq_shifter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shifter (
    .clock     (clock),
    .notReset  (notReset),
    .load      (sh_load),
    .en        (sh_en),
    .mode      (sh_mode),
    .load_val  (sh_val),
    .load_cnt  (sh_cnt_ld),
    .cnt       (sh_cnt),
    .q_next_c  (sh_next_c),
    .out_bit_c (sh_out_c)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned PW = 2 * WIDTH;
  logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum_c;

  // The shifter walks B from its LSB; each set bit adds the shifted multiplicand.
  assign acc_sum_c = acc_q + (sh_out_c ? mcand_q : '0);

  always_ff @(posedge clock) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    y_d       = y;
    cout_d    = cout;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_en     = 1'b0;
    sh_mode   = SH_R;
    sh_val    = a;
    sh_cnt_ld = CW'(n_c);
`ifdef ALU_SEQ_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_c)
            OP_SHL, OP_SHR, OP_ASR: begin
              if (n_c == '0) begin
                y_d    = a;
                cout_d = 1'b0;
                done_d = 1'b0 | 1'b1;
              end else begin
                sh_load = 1'b1;
                if (op_c == OP_SHL) sh_mode = SH_L;
                else if (op_c == OP_SHR) sh_mode = SH_R;
                else sh_mode = SH_A;
                busy_d  = 1'b1;
                state_d = ST_SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              sh_load   = 1'b1;
              sh_mode   = SH_R;
              sh_val    = b;
              sh_cnt_ld = CW'(WIDTH);
              acc_d     = '0;
              mcand_d   = PW'(a);
              busy_d    = 1'b1;
              state_d   = ST_MUL;
            end
`endif
            default: begin
              y_d    = y_c;
              cout_d = cout_c;
              done_d = 1'b1;
            end
          endcase
        end
      end
      // Final shift is taken straight from the shifter's next value into y.
      ST_SHIFT: begin
        sh_en = 1'b1;
        if (sh_cnt == CW'(1)) begin
          y_d     = sh_next_c;
          cout_d  = sh_out_c;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          busy_d = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        sh_en   = 1'b1;
        acc_d   = acc_sum_c;
        mcand_d = mcand_q << 1;
        if (sh_cnt == CW'(1)) begin
          y_d     = acc_sum_c[WIDTH-1:0];
          cout_d  = |acc_sum_c[PW-1:WIDTH];
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          busy_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign zout_d = done_d ? (y_d == '0) : zout;

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q <= ST_IDLE;
      y       <= '0;
      cout    <= 1'b0;
      zout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      cout    <= cout_d;
      zout    <= zout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clock;
  logic        notReset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        signed_cmp;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic        cout;
  logic        zout;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clock      (clock),
    .notReset   (notReset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .signed_cmp (signed_cmp),
    .busy       (busy),
    .done       (done),
    .y          (y),
    .cout       (cout),
    .zout       (zout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: result, carry and done latency (edges after the accepting edge).
  task automatic model(input logic [3:0] o, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic isc,
                       output logic [15:0] ey, output logic ec, output int lat);
    int n;
    logic [16:0] s;
    logic [31:0] p;
    n   = int'(ib[3:0]);
    ey  = 16'h0;
    ec  = 1'b0;
    lat = 1;
    s   = 17'h0;
    p   = 32'h0;
    case (o)
      4'd0: ey = ia;
      4'd1: ey = ib;
      4'd2, 4'd3: begin
        if (o == 4'd2) s = 17'(ia) + 17'(ib) + 17'(ic);
        else           s = 17'(ia) + 17'(16'hFFFF - ib) + 17'(ic);
        ey = s[15:0];
        ec = s[16];
        if (isc && (ia[15] != ib[15])) ec = ~ec;
      end
      4'd4: ey = ia & ib;
      4'd5: ey = ia | ib;
      4'd6: ey = ia ^ ib;
      4'd7: ey = ~ia;
      4'd8: begin ey = ia - 16'd1; ec = (ia != 16'd0); end
      4'd9: begin ey = ia[7] ? (16'hFF00 | ia) & 16'hFFFF : ia & 16'h00FF; ec = ia[7]; end
      4'd10, 4'd11, 4'd12: begin
        if (n == 0) ey = ia;
        else begin
          lat = n + 1;
          if (o == 4'd10) begin ey = ia << n; ec = ia[16 - n]; end
          else if (o == 4'd11) begin ey = ia >> n; ec = ia[n - 1]; end
          else begin ey = 16'($signed(ia) >>> n); ec = ia[n - 1]; end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      4'd13: begin
        p   = 32'(ia) * 32'(ib);
        ey  = p[15:0];
        ec  = (p[31:16] != 16'h0);
        lat = 17;
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op from idle; optionally pulse a stray start while busy and/or in FIN.
  task automatic run_op(input logic [3:0] o, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic isc, input bit disturb, input bit poke_fin);
    logic [15:0] ey;
    logic        ec;
    int          lat;
    int          got;
    model(o, ia, ib, ic, isc, ey, ec, lat);
    op = o; a = ia; b = ib; cin = ic; signed_cmp = isc; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); signed_cmp = 1'($urandom);
    got = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e > 1) begin @(posedge clock); #1; end
      start = 1'b0;
      if (done) begin got = e; break; end
      if (e == 1 && lat > 1) check("busy_first", 32'(busy), 32'd1);
      if (disturb && e == 2 && lat > 3) begin start = 1'b1; op = 4'd2; end
    end
    start = 1'b0;
    if (got == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(got), 32'(lat));
      check("y", 32'(y), 32'(ey));
      check("cout", 32'(cout), 32'(ec));
      check("zout", 32'(zout), 32'(ey == 16'h0));
      check("busy_at_done", 32'(busy), 32'd0);
    end
    if (poke_fin && lat > 1) begin start = 1'b1; op = 4'd0; a = 16'h5A5A; end
    @(posedge clock); #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    if (poke_fin && lat > 1) begin
      @(posedge clock); #1;
      check("fin_start_ignored", 32'(done), 32'd0);
      check("fin_y_hold", 32'(y), 32'(ey));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    notReset = 1'b0; start = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
    cin = 1'b0; signed_cmp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_y", 32'(y), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_zout", 32'(zout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    notReset = 1'b1;
    @(posedge clock); #1;
    check("idle_zout_hold", 32'(zout), 32'd0);

    run_op(4'd2,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(4'd3,  16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0);
    run_op(4'd3,  16'h8000, 16'h0001, 1'b1, 1'b0, 0, 0);
    run_op(4'd11, 16'h8001, 16'h0004, 1'b0, 1'b0, 0, 1);
    run_op(4'd12, 16'h8001, 16'h0004, 1'b0, 1'b0, 0, 0);
    run_op(4'd10, 16'h8001, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op(4'd10, 16'h8001, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op(4'd10, 16'h0003, 16'h0005, 1'b0, 1'b0, 1, 1);
    run_op(4'd13, 16'h0100, 16'h0101, 1'b0, 1'b0, 1, 1);
    run_op(4'd9,  16'h0080, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op(4'd9,  16'h007F, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op(4'd8,  16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op(4'd14, 16'h1234, 16'h5678, 1'b1, 1'b0, 0, 0);
    run_op(4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 0, 0);

    // Reset in the middle of a shift aborts it without a done.
    run_op(4'd0, 16'h1234, 16'h0000, 1'b0, 1'b0, 0, 0);
    op = 4'd11; a = 16'hF0F0; b = 16'h0008; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    notReset = 1'b0;
    @(posedge clock); #1;
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    notReset = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
